// File: rtl/self_destruct_sequencer.sv
// Self-destruct controller: 2-of-3 danger vote, persistence-gated arming, 8-step LED
// countdown and sticky detonation, all advanced by a single-cycle tick enable.
module self_destruct_sequencer #(
    parameter int unsigned TICKS_PER_STEP = 100,
    parameter int unsigned ARM_TICKS      = 3,
    parameter int unsigned DMG_THRESH     = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       in_combat,
    input  logic       in_danger,
    input  logic       immobilized,
    input  logic [6:0] damage,
    output logic [7:0] leds,
    output logic [1:0] state,
    output logic       detonate
);

    localparam int unsigned STEP_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam int unsigned ARM_W  = (ARM_TICKS > 1) ? $clog2(ARM_TICKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_ARMING    = 2'b01,
        S_COUNTDOWN = 2'b10,
        S_DETONATED = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          leds_q, leds_d;
    logic                detonate_q, detonate_d;
    logic [ARM_W-1:0]    arm_cnt_q, arm_cnt_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic                dmg_vote_c;
    logic                vote_c;

    assign dmg_vote_c = (damage > 7'(DMG_THRESH));
    assign vote_c     = (in_danger & dmg_vote_c) | (in_danger & immobilized) |
                        (dmg_vote_c & immobilized);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            leds_q     <= 8'h00;
            detonate_q <= 1'b0;
            arm_cnt_q  <= '0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            leds_q     <= leds_d;
            detonate_q <= detonate_d;
            arm_cnt_q  <= arm_cnt_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    // Next-state logic; nothing moves on cycles without a tick.
    always_comb begin
        state_d    = state_q;
        leds_d     = leds_q;
        detonate_d = detonate_q;
        arm_cnt_d  = arm_cnt_q;
        step_cnt_d = step_cnt_q;
        if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    leds_d = 8'h00;
                    if (in_combat && vote_c) begin
                        state_d   = S_ARMING;
                        arm_cnt_d = '0;
                    end
                end
                S_ARMING: begin
                    // Losing combat or the vote wins over arm completion.
                    if (!in_combat || !vote_c) begin
                        state_d   = S_IDLE;
                        arm_cnt_d = '0;
                    end else if (arm_cnt_q == ARM_W'(ARM_TICKS - 1)) begin
                        state_d    = S_COUNTDOWN;
                        leds_d     = 8'hFF;
                        step_cnt_d = '0;
                        arm_cnt_d  = '0;
                    end else begin
                        arm_cnt_d = arm_cnt_q + ARM_W'(1);
                    end
                end
                S_COUNTDOWN: begin
                    // Committed: only leaving combat aborts from here.
                    if (!in_combat) begin
                        state_d    = S_IDLE;
                        leds_d     = 8'h00;
                        arm_cnt_d  = '0;
                        step_cnt_d = '0;
                    end else if (step_cnt_q == STEP_W'(TICKS_PER_STEP - 1)) begin
                        step_cnt_d = '0;
                        if (leds_q == 8'h01) begin
                            state_d    = S_DETONATED;
                            leds_d     = 8'hFF;
                            detonate_d = 1'b1;
                        end else begin
                            leds_d = leds_q >> 1;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + STEP_W'(1);
                    end
                end
                S_DETONATED: begin
                    leds_d     = 8'hFF;
                    detonate_d = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign leds     = leds_q;
    assign state    = state_q;
    assign detonate = detonate_q;

endmodule

// File: tb/tb_self_destruct_sequencer.sv
// Directed-vector bench for self_destruct_sequencer with TICKS_PER_STEP=4, ARM_TICKS=3.
module tb_self_destruct_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       in_combat;
    logic       in_danger;
    logic       immobilized;
    logic [6:0] damage;
    logic [7:0] leds;
    logic [1:0] state;
    logic       detonate;

    int checks   = 0;
    int failures = 0;

    self_destruct_sequencer #(
        .TICKS_PER_STEP(4),
        .ARM_TICKS     (3),
        .DMG_THRESH    (50)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .in_combat  (in_combat),
        .in_danger  (in_danger),
        .immobilized(immobilized),
        .damage     (damage),
        .leds       (leds),
        .state      (state),
        .detonate   (detonate)
    );

    always #5 clk = ~clk;

    task automatic pulse(input int n);
        repeat (n) begin
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    task automatic set_in(input logic c, input logic d, input logic im, input logic [6:0] dmg);
        in_combat   = c;
        in_danger   = d;
        immobilized = im;
        damage      = dmg;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({state, leds, detonate} !== {2'b00, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got state=%b leds=%h det=%b want 00/00/0", state, leds, detonate);
        end
    endtask

    task automatic test_no_tick();
        set_in(1'b1, 1'b1, 1'b1, 7'd90);
        repeat (10) @(negedge clk);
        checks++;
        if (state !== 2'b00) begin
            failures++;
            $display("FAIL no_tick_ignored: got state=%b want 00", state);
        end
    endtask

    task automatic test_threshold();
        set_in(1'b1, 1'b1, 1'b0, 7'd50);
        pulse(20);
        checks++;
        if (state !== 2'b00) begin
            failures++;
            $display("FAIL dmg_eq_thresh: got state=%b want 00", state);
        end
        // Vote present but not in combat.
        set_in(1'b0, 1'b0, 1'b1, 7'd51);
        pulse(3);
        checks++;
        if (state !== 2'b00) begin
            failures++;
            $display("FAIL no_combat: got state=%b want 00", state);
        end
    endtask

    task automatic test_full_countdown();
        set_in(1'b1, 1'b1, 1'b0, 7'd60);
        pulse(1);
        checks++;
        if (state !== 2'b01) begin
            failures++;
            $display("FAIL arm_entry: got state=%b want 01", state);
        end
        pulse(2);
        checks++;
        if (state !== 2'b01) begin
            failures++;
            $display("FAIL arm_hold: got state=%b want 01", state);
        end
        pulse(1);
        checks++;
        if ({state, leds} !== {2'b10, 8'hFF}) begin
            failures++;
            $display("FAIL cd_entry: got state=%b leds=%h want 10/FF", state, leds);
        end
        pulse(3);
        checks++;
        if (leds !== 8'hFF) begin
            failures++;
            $display("FAIL cd_pre_shift: got leds=%h want FF", leds);
        end
        pulse(1);
        checks++;
        if (leds !== 8'h7F) begin
            failures++;
            $display("FAIL cd_first_shift: got leds=%h want 7F", leds);
        end
        pulse(24);
        checks++;
        if ({state, leds, detonate} !== {2'b10, 8'h01, 1'b0}) begin
            failures++;
            $display("FAIL cd_last_step: got state=%b leds=%h det=%b want 10/01/0", state, leds, detonate);
        end
        pulse(3);
        checks++;
        if ({state, leds} !== {2'b10, 8'h01}) begin
            failures++;
            $display("FAIL cd_before_det: got state=%b leds=%h want 10/01", state, leds);
        end
        pulse(1);
        checks++;
        if ({state, leds, detonate} !== {2'b11, 8'hFF, 1'b1}) begin
            failures++;
            $display("FAIL detonate: got state=%b leds=%h det=%b want 11/FF/1", state, leds, detonate);
        end
    endtask

    task automatic test_detonated_hold();
        set_in(1'b0, 1'b0, 1'b0, 7'd0);
        pulse(3);
        set_in(1'b1, 1'b1, 1'b1, 7'd0);
        pulse(2);
        set_in(1'b0, 1'b1, 1'b0, 7'd0);
        pulse(2);
        checks++;
        if ({state, leds, detonate} !== {2'b11, 8'hFF, 1'b1}) begin
            failures++;
            $display("FAIL det_hold: got state=%b leds=%h det=%b want 11/FF/1", state, leds, detonate);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({state, leds, detonate} !== {2'b00, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL async_reset: got state=%b leds=%h det=%b want 00/00/0", state, leds, detonate);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_arm_abort();
        set_in(1'b1, 1'b0, 1'b1, 7'd70);
        pulse(2);
        set_in(1'b1, 1'b0, 1'b0, 7'd70);
        pulse(1);
        checks++;
        if (state !== 2'b00) begin
            failures++;
            $display("FAIL arm_abort: got state=%b want 00", state);
        end
        set_in(1'b1, 1'b1, 1'b1, 7'd0);
        pulse(3);
        checks++;
        if (state !== 2'b01) begin
            failures++;
            $display("FAIL rearm_partial: got state=%b want 01", state);
        end
        pulse(1);
        checks++;
        if ({state, leds} !== {2'b10, 8'hFF}) begin
            failures++;
            $display("FAIL rearm_full: got state=%b leds=%h want 10/FF", state, leds);
        end
    endtask

    task automatic test_vote_drop_countdown();
        pulse(8);
        checks++;
        if ({state, leds} !== {2'b10, 8'h3F}) begin
            failures++;
            $display("FAIL cd_at_3f: got state=%b leds=%h want 10/3F", state, leds);
        end
        set_in(1'b1, 1'b0, 1'b0, 7'd0);
        pulse(4);
        checks++;
        if ({state, leds} !== {2'b10, 8'h1F}) begin
            failures++;
            $display("FAIL cd_vote_ignored: got state=%b leds=%h want 10/1F", state, leds);
        end
        set_in(1'b0, 1'b0, 1'b0, 7'd0);
        pulse(1);
        checks++;
        if ({state, leds} !== {2'b00, 8'h00}) begin
            failures++;
            $display("FAIL cd_abort: got state=%b leds=%h want 00/00", state, leds);
        end
    endtask

    task automatic test_reset_mid_countdown();
        set_in(1'b1, 1'b1, 1'b0, 7'd99);
        pulse(4);
        pulse(5);
        checks++;
        if ({state, leds} !== {2'b10, 8'h7F}) begin
            failures++;
            $display("FAIL mid_cd_setup: got state=%b leds=%h want 10/7F", state, leds);
        end
        @(negedge clk);
        tick  = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({state, leds, detonate} !== {2'b00, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL mid_cd_reset: got state=%b leds=%h det=%b want 00/00/0", state, leds, detonate);
        end
        reset = 1'b0;
        tick  = 1'b0;
        pulse(1);
        checks++;
        if (state !== 2'b01) begin
            failures++;
            $display("FAIL post_reset_arm: got state=%b want 01", state);
        end
    endtask

    initial begin
        reset = 1'b1;
        tick  = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 7'd0);
        repeat (2) @(negedge clk);
        test_reset();
        test_no_tick();
        test_threshold();
        test_full_countdown();
        test_detonated_hold();
        test_arm_abort();
        test_vote_drop_countdown();
        test_reset_mid_countdown();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
